lifo_frame_ctrl: RTL and testbench

Frame-reversing controller that wraps the 4-deep, 4-bit synchronous stack. It accepts a valid/ready nibble stream delimited by `in_last`, pushes each frame into the stack, then pops it and emits the frame reversed on a valid/ready output stream. It sits directly upstream of the stack, which it commands, and directly downstream of it, consuming the popped data. Frames longer than the stack are truncated and counted.

---
 rtl/lifo_pkg.sv | 25 ++
 rtl/sat_counter.sv | 26 ++
 rtl/lifo_frame_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lifo_frame_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared definitions for the 4x4 stack and the frame-reversing controller
// that drives it.
package lifo_pkg;

  localparam int LIFO_DW    = 4;
  localparam int LIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } lifo_state_e;

  // True when the controller's view of occupancy contradicts the stack flags.
  function automatic logic flags_disagree(
    input logic occ_zero,
    input logic occ_full,
    input logic stk_empty,
    input logic stk_full
  );
    return (occ_zero ^ stk_empty) | (occ_full ^ stk_full);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Increment-only counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count register with synchronous reset and saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/lifo_frame_ctrl.sv
// Frame reverser: pushes an input frame into the external stack, then pops
// and emits it nibble by nibble; nibbles beyond the stack depth are dropped.
module lifo_frame_ctrl
  import lifo_pkg::*;
#(
  parameter int DW    = LIFO_DW,
  parameter int DEPTH = LIFO_DEPTH,
  parameter int OVW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           out_last,
  output logic           stk_en,
  output logic           stk_pop,
  output logic [DW-1:0]  stk_din,
  input  logic [DW-1:0]  stk_dout,
  input  logic           stk_full,
  input  logic           stk_empty,
  output logic [OVW-1:0] ovf_cnt,
  output logic           err_sync
);

  localparam int OCCW = $clog2(DEPTH + 1);
  localparam logic [OCCW-1:0] OCC_MAX  = OCCW'(DEPTH);
  localparam logic [OCCW-1:0] OCC_ONE  = {{(OCCW-1){1'b0}}, 1'b1};
  localparam logic [OCCW-1:0] OCC_ZERO = {OCCW{1'b0}};

  lifo_state_e     state_r, state_nxt_s;
  logic [OCCW-1:0] occ_r;
  logic [DW-1:0]   out_data_r;
  logic            out_valid_r, out_last_r, err_sync_r;
  logic            push_s, drop_s;
  logic            occ_zero_s, occ_full_s, chk_flags_s;

  assign occ_zero_s  = (occ_r == OCC_ZERO);
  assign occ_full_s  = (occ_r == OCC_MAX);
  // Occupancy and flags only agree in states where push/pop and occ move together.
  assign chk_flags_s = (state_r == FILL) || (state_r == POP);

  // Next-state and combinational stack command / input handshake.
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    stk_en      = 1'b0;
    stk_pop     = 1'b0;
    stk_din     = {DW{1'b0}};
    push_s      = 1'b0;
    drop_s      = 1'b0;
    if (rst) begin
      // The stack only honours its reset while enabled.
      stk_en = 1'b1;
    end else begin
      case (state_r)
        FILL: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (occ_r < OCC_MAX) begin
              push_s  = 1'b1;
              stk_en  = 1'b1;
              stk_din = in_data;
            end else begin
              drop_s = 1'b1;
            end
            if (in_last) begin
              state_nxt_s = POP;
            end else begin
              state_nxt_s = FILL;
            end
          end else begin
            state_nxt_s = FILL;
          end
        end
        POP: begin
          stk_en      = 1'b1;
          stk_pop     = 1'b1;
          state_nxt_s = CAPT;
        end
        CAPT: begin
          state_nxt_s = SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (out_last_r) begin
              state_nxt_s = FILL;
            end else begin
              state_nxt_s = POP;
            end
          end else begin
            state_nxt_s = SEND;
          end
        end
        default: begin
          state_nxt_s = FILL;
        end
      endcase
    end
  end

  // State register and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
      occ_r   <= OCC_ZERO;
    end else begin
      state_r <= state_nxt_s;
      if (push_s) begin
        occ_r <= occ_r + OCC_ONE;
      end else if (state_r == CAPT) begin
        occ_r <= occ_r - OCC_ONE;
      end else begin
        occ_r <= occ_r;
      end
    end
  end

  // Output stream registers: load on capture, hold until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (state_r == CAPT) begin
      out_data_r  <= stk_dout;
      out_valid_r <= 1'b1;
      out_last_r  <= (occ_r == OCC_ONE);
    end else if ((state_r == SEND) && out_ready) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= out_valid_r;
      out_last_r  <= out_last_r;
    end
  end

  // Registered occupancy/flag consistency pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sync_r <= 1'b0;
    end else begin
      err_sync_r <= chk_flags_s &&
                    flags_disagree(occ_zero_s, occ_full_s, stk_empty, stk_full);
    end
  end

  sat_counter #(
    .W (OVW)
  ) u_ovf_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop_s),
    .cnt (ovf_cnt)
  );

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign err_sync  = err_sync_r;

endmodule

// File: tb/tb_lifo_frame_ctrl.sv
// Directed bench for lifo_frame_ctrl with a behavioural 4x4 stack model.
module tb_lifo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [3:0] in_data;
  logic       out_valid, out_ready, out_last;
  logic [3:0] out_data;
  logic       stk_en, stk_pop, stk_full, stk_empty;
  logic [3:0] stk_din, stk_dout;
  logic [7:0] ovf_cnt;
  logic       err_sync;

  int errors = 0;
  int checks = 0;

  logic [3:0] mem [4];
  logic [2:0] sp;
  logic       flip_empty = 1'b0;
  logic       watch_en   = 1'b0;
  logic       err_seen   = 1'b0;

  always #5 clk = ~clk;

  lifo_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .stk_en    (stk_en),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .ovf_cnt   (ovf_cnt),
    .err_sync  (err_sync)
  );

  // Stack model: acts only while enabled, reset included.
  always_ff @(posedge clk) begin
    if (stk_en) begin
      if (rst) begin
        sp       <= 3'd0;
        stk_dout <= 4'd0;
      end else if (!stk_pop) begin
        if (sp < 3'd4) begin
          mem[sp[1:0]] <= stk_din;
          sp           <= sp + 3'd1;
        end
      end else if (sp != 3'd0) begin
        stk_dout <= mem[2'(sp - 3'd1)];
        sp       <= sp - 3'd1;
      end
    end
  end

  assign stk_full  = (sp == 3'd4);
  assign stk_empty = (sp == 3'd0) ^ flip_empty;

  always @(negedge clk) begin
    if (watch_en && (err_sync === 1'b1)) err_seen <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input beat in FILL; exp_push says whether the stack should see a push.
  task automatic push(input logic [3:0] d, input logic last, input logic exp_push);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    chk("in_ready_fill", 8'(in_ready), 8'd1);
    chk("push_en", 8'({stk_en, stk_pop}), exp_push ? 8'd2 : 8'd0);
    chk("push_din", 8'(stk_din), exp_push ? 8'(d) : 8'd0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'd0;
  endtask

  // Starting in POP with out_ready high: POP, CAPT, SEND then handshake.
  task automatic drain(input logic [3:0] d, input logic last);
    chk("pop_cmd", 8'({stk_en, stk_pop}), 8'd3);
    chk("in_ready_pop", 8'(in_ready), 8'd0);
    tick();
    tick();
    chk("out_valid", 8'(out_valid), 8'd1);
    chk("out_data", 8'(out_data), 8'(d));
    chk("out_last", 8'(out_last), 8'(last));
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; in_last = 1'b0; out_ready = 1'b1;

    // Reset
    tick(); tick();
    chk("rst_stk_cmd", 8'({stk_en, stk_pop}), 8'd2);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_ovf", ovf_cnt, 8'd0);
    chk("rst_in_ready", 8'(in_ready), 8'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 8'(in_ready), 8'd1);
    chk("post_rst_empty", 8'(stk_empty), 8'd1);
    chk("post_rst_stk_en", 8'(stk_en), 8'd0);
    watch_en = 1'b1;

    // 3-nibble frame
    push(4'h1, 1'b0, 1'b1);
    push(4'h2, 1'b0, 1'b1);
    push(4'h3, 1'b1, 1'b1);
    chk("first_out_pop", 8'(out_valid), 8'd0);
    drain(4'h3, 1'b0);
    drain(4'h2, 1'b0);
    drain(4'h1, 1'b1);
    chk("f3_in_ready_after", 8'(in_ready), 8'd1);
    chk("f3_out_valid_after", 8'(out_valid), 8'd0);

    // Overflow: 6 nibbles into a 4-deep stack
    push(4'h1, 1'b0, 1'b1);
    push(4'h2, 1'b0, 1'b1);
    push(4'h3, 1'b0, 1'b1);
    push(4'h4, 1'b0, 1'b1);
    chk("ovf_full", 8'(stk_full), 8'd1);
    chk("ovf_occ", 8'(dut.occ_r), 8'd4);
    push(4'h5, 1'b0, 1'b0);
    push(4'h6, 1'b1, 1'b0);
    chk("ovf_cnt", ovf_cnt, 8'd2);
    drain(4'h4, 1'b0);
    drain(4'h3, 1'b0);
    drain(4'h2, 1'b0);
    drain(4'h1, 1'b1);
    chk("ovf_empty_after", 8'(stk_empty), 8'd1);

    // Backpressure
    out_ready = 1'b0;
    push(4'hA, 1'b0, 1'b1);
    push(4'hB, 1'b1, 1'b1);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 8'(out_valid), 8'd1);
      chk("bp_data", 8'(out_data), 8'hB);
      chk("bp_in_ready", 8'(in_ready), 8'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_data", 8'(out_data), 8'hB);
    chk("bp_release_last", 8'(out_last), 8'd0);
    tick();
    chk("bp_valid_drop", 8'(out_valid), 8'd0);
    drain(4'hA, 1'b1);

    // Single-nibble frames back to back
    push(4'h7, 1'b1, 1'b1);
    drain(4'h7, 1'b1);
    push(4'h8, 1'b1, 1'b1);
    drain(4'h8, 1'b1);
    chk("ovf_held", ovf_cnt, 8'd2);

    // Reset mid-drain
    out_ready = 1'b0;
    push(4'h1, 1'b0, 1'b1);
    push(4'h2, 1'b0, 1'b1);
    push(4'h3, 1'b0, 1'b1);
    push(4'h4, 1'b1, 1'b1);
    tick(); tick();
    chk("md_send_valid", 8'(out_valid), 8'd1);
    chk("md_send_data", 8'(out_data), 8'h4);
    rst = 1'b1;
    tick();
    chk("md_out_valid", 8'(out_valid), 8'd0);
    chk("md_occ", 8'(dut.occ_r), 8'd0);
    chk("md_empty", 8'(stk_empty), 8'd1);
    chk("md_ovf", ovf_cnt, 8'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("md_in_ready", 8'(in_ready), 8'd1);
    push(4'h5, 1'b1, 1'b1);
    drain(4'h5, 1'b1);

    watch_en = 1'b0;
    chk("no_err_sync", 8'(err_seen), 8'd0);

    // Flag disagreement: stack claims non-empty while occ is zero
    flip_empty = 1'b1;
    tick();
    chk("err_sync_pulse", 8'(err_sync), 8'd1);
    flip_empty = 1'b0;
    tick();
    chk("err_sync_clear", 8'(err_sync), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
